// File: rtl/game_phase_if.sv
`default_nettype none
// ============================================================================
// game_phase_if : sequencer <-> datapath signal bundle for game_phase_ctrl
// Rev 1.0
// ============================================================================
interface game_phase_if #(
  parameter int NUM_UPD  = 2,
  parameter int HEALTH_W = 8,
  parameter int FRAME_W  = 16
);
  logic [HEALTH_W-1:0] ship_health;
  logic                draw_done;
  logic                pause_req;
  logic                start_game_en;
  logic                write_en;
  logic [NUM_UPD-1:0]  upd_en;
  logic                game_over_en;
  logic                paused;
  logic                frame_overrun;
  logic [FRAME_W-1:0]  frame_count;
  logic [2:0]          state;

  modport master (
    input  ship_health, draw_done, pause_req,
    output start_game_en, write_en, upd_en, game_over_en, paused,
           frame_overrun, frame_count, state
  );

  modport slave (
    output ship_health, draw_done, pause_req,
    input  start_game_en, write_en, upd_en, game_over_en, paused,
           frame_overrun, frame_count, state
  );
endinterface
`default_nettype wire

// File: rtl/game_phase_ctrl.sv
`default_nettype none
// ============================================================================
// game_phase_ctrl : frame-ticked START/DRAW/UPDATE/PAUSE/GAMEOVER sequencer
// Rev 1.0
// ============================================================================
module game_phase_ctrl #(
  parameter int TICK_DIV       = 3_125_000,
  parameter int NUM_UPD        = 2,
  parameter int HEALTH_W       = 8,
  parameter int FRAME_W        = 16,
  parameter int GAMEOVER_TICKS = 32
) (
  input  logic         clk,
  input  logic         reset,
  game_phase_if.master bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(NUM_UPD + 1);
  localparam int GO_W  = $clog2(GAMEOVER_TICKS + 1);
  localparam logic [CNT_W-1:0] c_tick_reload = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] c_upd_last    = IDX_W'(NUM_UPD);
  localparam logic [GO_W-1:0]  c_go_last     = GO_W'(GAMEOVER_TICKS - 1);

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_DRAW     = 3'd1,
    S_UPDATE   = 3'd2,
    S_GAMEOVER = 3'd3,
    S_PAUSE    = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_tick_cnt;
  logic [IDX_W-1:0]    r_upd_idx;
  logic                r_done;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [GO_W-1:0]     r_go_cnt;
  logic [HEALTH_W-1:0] w_health;
  logic                w_tick, w_done_seen, w_strobing, w_frame_inc, w_overrun;
  logic                w_go_entry;
  logic [NUM_UPD-1:0]  w_upd_en;

  assign w_health    = bus.ship_health;
  assign w_tick      = (r_tick_cnt == '0);
  assign w_done_seen = r_done | bus.draw_done;
  assign w_strobing  = (r_state == S_UPDATE) && (r_upd_idx < c_upd_last);
  assign w_go_entry  = (w_state_nxt == S_GAMEOVER) && (r_state != S_GAMEOVER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_START;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_inc = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      S_START: if (w_tick) w_state_nxt = S_DRAW;
      S_DRAW: begin
        if (w_tick) begin
          if (w_done_seen) w_state_nxt = S_UPDATE;
          else             w_overrun   = 1'b1;
        end
      end
      S_UPDATE: begin
        // Health is judged only once every updater has had its strobe
        if (!w_strobing) begin
          if (w_health == '0) begin
            w_state_nxt = S_GAMEOVER;
          end else if (w_tick) begin
            w_frame_inc = 1'b1;
            w_state_nxt = bus.pause_req ? S_PAUSE : S_DRAW;
          end
        end
      end
      S_PAUSE:    if (!bus.pause_req) w_state_nxt = S_DRAW;
      S_GAMEOVER: if (w_tick && (r_go_cnt == c_go_last)) w_state_nxt = S_START;
      default:    w_state_nxt = S_START;
    endcase
  end

  always_comb begin
    w_upd_en = '0;
    for (int i = 0; i < NUM_UPD; i++)
      w_upd_en[i] = w_strobing && (r_upd_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= c_tick_reload;
      r_upd_idx   <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_go_cnt    <= '0;
    end else begin
      // Reload on GAMEOVER entry so the hold spans whole frame periods
      if ((r_state == S_PAUSE) || w_go_entry || w_tick) r_tick_cnt <= c_tick_reload;
      else                                              r_tick_cnt <= r_tick_cnt - 1'b1;

      if ((r_state == S_UPDATE) && (w_state_nxt == S_UPDATE)) begin
        if (w_strobing) r_upd_idx <= r_upd_idx + 1'b1;
      end else begin
        r_upd_idx <= '0;
      end

      if (r_state != S_DRAW)  r_done <= 1'b0;
      else if (bus.draw_done) r_done <= 1'b1;

      if (w_state_nxt == S_START) r_frame_cnt <= '0;
      else if (w_frame_inc)       r_frame_cnt <= r_frame_cnt + 1'b1;

      if (r_state != S_GAMEOVER) r_go_cnt <= '0;
      else if (w_tick)           r_go_cnt <= (r_go_cnt == c_go_last) ? '0 : r_go_cnt + 1'b1;
    end
  end

  assign bus.start_game_en = (r_state == S_START);
  assign bus.write_en      = (r_state == S_START) || (r_state == S_DRAW);
  assign bus.upd_en        = w_upd_en;
  assign bus.game_over_en  = (r_state == S_GAMEOVER);
  assign bus.paused        = (r_state == S_PAUSE);
  assign bus.frame_overrun = w_overrun;
  assign bus.frame_count   = r_frame_cnt;
  assign bus.state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_phase_ctrl.sv
`default_nettype none
// ============================================================================
// tb_game_phase_ctrl : randomized run of game_phase_ctrl against a frame model
// Rev 1.0
// ============================================================================
module tb_game_phase_ctrl;

  localparam int TICK_DIV = 8;
  localparam int NUM_UPD  = 3;
  localparam int GO_TICKS = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  game_phase_if #(.NUM_UPD(NUM_UPD), .HEALTH_W(8), .FRAME_W(16)) bus();

  game_phase_ctrl #(
    .TICK_DIV(TICK_DIV), .NUM_UPD(NUM_UPD), .HEALTH_W(8),
    .FRAME_W(16), .GAMEOVER_TICKS(GO_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number, clocks left before the next tick,
  // strobes already issued this UPDATE, draw seen, frames, GAMEOVER ticks.
  int m_phase, m_left, m_strobe, m_frames, m_go;
  bit m_seen;
  int go_run, reset_hits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_phase = 0; m_left = TICK_DIV - 1; m_strobe = 0;
    m_frames = 0; m_go = 0; m_seen = 0;
  endfunction

  function automatic void model_step(bit dd, bit pr, int hp);
    bit tick = (m_left == 0);
    int nxt  = m_phase;
    case (m_phase)
      0: if (tick) nxt = 1;
      1: if (tick && (m_seen || dd)) nxt = 2;
      2: if (m_strobe == NUM_UPD) begin
           if (hp == 0) nxt = 3;
           else if (tick) begin
             m_frames = (m_frames + 1) % 65536;
             nxt = pr ? 4 : 1;
           end
         end
      3: if (tick) begin
           m_go++;
           if (m_go == GO_TICKS) begin m_go = 0; nxt = 0; end
         end
      default: if (!pr) nxt = 1;
    endcase
    if (m_phase == 4 || tick || (nxt == 3 && m_phase != 3)) m_left = TICK_DIV - 1;
    else m_left--;
    if (nxt == 1 && m_phase != 1) m_seen = 0;
    else if (m_phase == 1 && dd) m_seen = 1;
    if (nxt == 2 && m_phase == 2) begin
      if (m_strobe < NUM_UPD) m_strobe++;
    end else m_strobe = 0;
    if (nxt == 0) m_frames = 0;
    m_phase = nxt;
  endfunction

  task automatic check_outputs();
    bit tick = (m_left == 0);
    int exp_upd = (m_phase == 2 && m_strobe < NUM_UPD) ? (1 << m_strobe) : 0;
    chk("state",    bus.state,         m_phase);
    chk("start_en", bus.start_game_en, m_phase == 0);
    chk("write_en", bus.write_en,      m_phase <= 1);
    chk("upd_en",   bus.upd_en,        exp_upd);
    chk("go_en",    bus.game_over_en,  m_phase == 3);
    chk("paused",   bus.paused,        m_phase == 4);
    chk("overrun",  bus.frame_overrun, m_phase == 1 && tick && !(m_seen || bus.draw_done));
    chk("frames",   bus.frame_count,   m_frames);
    if (bus.game_over_en) go_run++;
    else if (go_run > 0) begin
      chk("go_len", go_run, TICK_DIV * GO_TICKS);
      go_run = 0;
    end
  endtask

  // One clock: outputs checked mid-cycle; optional async reset while upd_en=010.
  task automatic run_cycle(input bit try_reset);
    @(negedge clk);
    check_outputs();
    if (try_reset && m_phase == 2 && m_strobe == 1) begin
      #2 reset = 1'b1;
      #1;
      chk("rst_upd",   bus.upd_en,        0);
      chk("rst_state", bus.state,         0);
      chk("rst_frame", bus.frame_count,   0);
      chk("rst_start", bus.start_game_en, 1);
      model_reset();
      reset_hits++;
      @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      model_step(bus.draw_done, bus.pause_req, int'(bus.ship_health));
      @(posedge clk);
      #1;
    end
  endtask

  int seg_dd[6]    = '{30, 3, 30, 30, 30, 15};
  int seg_zero[6]  = '{0, 0, 0, 20, 40, 5};
  int seg_pause[6] = '{0, 0, 5, 0, 10, 3};
  int seg_len[6]   = '{300, 300, 400, 400, 400, 600};

  initial begin
    n_checks = 0; n_pass = 0; go_run = 0; reset_hits = 0;
    reset = 1'b1;
    bus.ship_health = 8'd5;
    bus.draw_done   = 1'b0;
    bus.pause_req   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", bus.state, 0);
    chk("reset_start", bus.start_game_en, 1);
    chk("reset_write", bus.write_en, 1);
    chk("reset_upd",   bus.upd_en, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int s = 0; s < 6; s++) begin
      if (seg_pause[s] == 0) bus.pause_req = 1'b0;
      for (int c = 0; c < seg_len[s]; c++) begin
        bus.draw_done = ($urandom_range(99) < seg_dd[s]);
        if ($urandom_range(99) < seg_zero[s]) bus.ship_health = 8'd0;
        else bus.ship_health = 8'($urandom_range(255, 1));
        if ($urandom_range(99) < seg_pause[s]) bus.pause_req = ~bus.pause_req;
        run_cycle(s == 2 && reset_hits == 0);
      end
      if (s == 2) chk("rst_reached", reset_hits, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
